// File: rtl/cornice_mobile.sv
// rtl/cornice_mobile.sv - moving sprite position register with wrap/bounce motion and per-pixel frame hit test
module cornice_mobile #(
    parameter int H         = 1280,
    parameter int V         = 1024,
    parameter int LARGHEZZA = 100,
    parameter int ALTEZZA   = 100,
    parameter int SPESSORE  = 6,
    parameter int X0        = 0,
    parameter int Y0        = 0,
    parameter int VX0       = 2,
    parameter int VY0       = 1,
    parameter int VW        = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 FRAME_TICK,
    input  logic                 EN,
    input  logic                 MODE,
    input  logic                 LOAD,
    input  logic [10:0]          X_LOAD,
    input  logic [10:0]          Y_LOAD,
    input  logic signed [VW-1:0] VX_LOAD,
    input  logic signed [VW-1:0] VY_LOAD,
    input  logic [10:0]          X_CONTROLLO,
    input  logic [10:0]          Y_CONTROLLO,
    output logic [10:0]          X_POS,
    output logic [10:0]          Y_POS,
    output logic                 ESTERNO,
    output logic                 INTERNO,
    output logic                 CONFERMA,
    output logic                 RIMBALZO
);

    localparam logic [11:0] HW = 12'(H);
    localparam logic [11:0] VWID = 12'(V);

    logic [10:0]          x_q, x_d, y_q, y_d;
    logic signed [VW-1:0] vx_q, vx_d, vy_q, vy_d;
    logic                 est_q, est_d, int_q, int_d, conf_q, conf_d, rb_q, rb_d;
    logic [VW+11:0]       x_step, y_step;
    logic [11:0]          dx, dy;
    logic                 in_range, est_x, est_y, int_x, int_y;

    // One axis of motion: returns {reflected, new velocity, new position}.
    function automatic logic [VW+11:0] axis_step(input logic [10:0] pos,
                                                  input logic signed [VW-1:0] vel,
                                                  input logic mode,
                                                  input int span,
                                                  input int extent);
        logic signed [12:0]   nx, lim, sp;
        logic signed [VW-1:0] mag, nv;
        logic [10:0]          np;
        logic                 hit;
        sp  = 13'(span);
        lim = 13'(span - extent);
        nx  = $signed({2'b00, pos}) + $signed({{(13-VW){vel[VW-1]}}, vel});
        if (vel == {1'b1, {(VW-1){1'b0}}})
            mag = {1'b0, {(VW-1){1'b1}}};
        else
            mag = vel[VW-1] ? -vel : vel;
        np  = pos;
        nv  = vel;
        hit = 1'b0;
        if (!mode) begin
            if (nx < 0)
                nx = nx + sp;
            else if (nx >= sp)
                nx = nx - sp;
            np = 11'(nx);
        end else if (vel != '0) begin
            if (nx > lim) begin
                np  = 11'(lim);
                nv  = -mag;
                hit = 1'b1;
            end else if (nx < 0) begin
                np  = '0;
                nv  = mag;
                hit = 1'b1;
            end else begin
                np = 11'(nx);
            end
        end
        return {hit, nv, np};
    endfunction

    always_comb begin
        // Distances are taken modulo the screen so a rectangle straddling an edge wraps.
        dx = ({1'b0, X_CONTROLLO} >= {1'b0, x_q}) ? {1'b0, X_CONTROLLO} - {1'b0, x_q}
                                                  : {1'b0, X_CONTROLLO} + HW - {1'b0, x_q};
        dy = ({1'b0, Y_CONTROLLO} >= {1'b0, y_q}) ? {1'b0, Y_CONTROLLO} - {1'b0, y_q}
                                                  : {1'b0, Y_CONTROLLO} + VWID - {1'b0, y_q};
        in_range = ({1'b0, X_CONTROLLO} < HW) && ({1'b0, Y_CONTROLLO} < VWID);
        est_x = dx < 12'(LARGHEZZA);
        est_y = dy < 12'(ALTEZZA);
        int_x = (dx >= 12'(SPESSORE)) && (dx < 12'(LARGHEZZA - SPESSORE));
        int_y = (dy >= 12'(SPESSORE)) && (dy < 12'(ALTEZZA - SPESSORE));
        est_d  = in_range && est_x && est_y;
        int_d  = in_range && int_x && int_y;
        conf_d = est_d && !int_d;

        x_step = axis_step(x_q, vx_q, MODE, H, LARGHEZZA);
        y_step = axis_step(y_q, vy_q, MODE, V, ALTEZZA);

        x_d  = x_q;
        y_d  = y_q;
        vx_d = vx_q;
        vy_d = vy_q;
        rb_d = 1'b0;
        if (LOAD) begin
            x_d  = ({1'b0, X_LOAD} >= HW) ? X_LOAD - 11'(H) : X_LOAD;
            y_d  = ({1'b0, Y_LOAD} >= VWID) ? Y_LOAD - 11'(V) : Y_LOAD;
            vx_d = VX_LOAD;
            vy_d = VY_LOAD;
        end else if (FRAME_TICK && EN) begin
            x_d  = x_step[10:0];
            y_d  = y_step[10:0];
            vx_d = x_step[VW+10:11];
            vy_d = y_step[VW+10:11];
            rb_d = x_step[VW+11] | y_step[VW+11];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_q    <= 11'(X0);
            y_q    <= 11'(Y0);
            vx_q   <= VW'(VX0);
            vy_q   <= VW'(VY0);
            est_q  <= 1'b0;
            int_q  <= 1'b0;
            conf_q <= 1'b0;
            rb_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            est_q  <= est_d;
            int_q  <= int_d;
            conf_q <= conf_d;
            rb_q   <= rb_d;
        end
    end

    assign X_POS    = x_q;
    assign Y_POS    = y_q;
    assign ESTERNO  = est_q;
    assign INTERNO  = int_q;
    assign CONFERMA = conf_q;
    assign RIMBALZO = rb_q;

endmodule

// File: tb/tb_cornice_mobile.sv
// tb/tb_cornice_mobile.sv - bench for cornice_mobile: directed cases plus random traffic against a reference model
module tb_cornice_mobile;

    localparam int H = 1280, V = 1024, L = 100, A = 100, S = 6;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              FRAME_TICK = 1'b0, EN = 1'b1, MODE = 1'b0, LOAD = 1'b0;
    logic [10:0]       X_LOAD = '0, Y_LOAD = '0, X_CONTROLLO = '0, Y_CONTROLLO = '0;
    logic signed [5:0] VX_LOAD = '0, VY_LOAD = '0;
    logic [10:0]       X_POS, Y_POS;
    logic              ESTERNO, INTERNO, CONFERMA, RIMBALZO;

    int n_pass = 0, n_total = 0;
    int m_x, m_y, m_vx, m_vy;
    bit m_e, m_i, m_c, m_rb;

    cornice_mobile dut (
        .CLK(CLK), .RST(RST), .FRAME_TICK(FRAME_TICK), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .X_LOAD(X_LOAD), .Y_LOAD(Y_LOAD), .VX_LOAD(VX_LOAD), .VY_LOAD(VY_LOAD),
        .X_CONTROLLO(X_CONTROLLO), .Y_CONTROLLO(Y_CONTROLLO),
        .X_POS(X_POS), .Y_POS(Y_POS), .ESTERNO(ESTERNO), .INTERNO(INTERNO),
        .CONFERMA(CONFERMA), .RIMBALZO(RIMBALZO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_vx = 2; m_vy = 1;
        m_e = 0; m_i = 0; m_c = 0; m_rb = 0;
    endtask

    task automatic bounce_axis(inout int p, inout int v, input int span, input int ext, output bit hit);
        int nx, mag, lim;
        hit = 0;
        if (v == 0) return;
        nx  = p + v;
        lim = span - ext;
        mag = (v < 0) ? -v : v;
        if (mag > 31) mag = 31;
        if (nx > lim) begin
            p = lim; v = -mag; hit = 1;
        end else if (nx < 0) begin
            p = 0; v = mag; hit = 1;
        end else begin
            p = nx;
        end
    endtask

    task automatic model_edge();
        int dx, dy, px, py;
        bit hx, hy;
        if (RST) begin
            model_reset();
            return;
        end
        px = X_CONTROLLO; py = Y_CONTROLLO;
        dx = (px - m_x + H) % H;
        dy = (py - m_y + V) % V;
        m_e = (px < H) && (py < V) && dx < L && dy < A;
        m_i = (px < H) && (py < V) && dx >= S && dx < L - S && dy >= S && dy < A - S;
        m_c = m_e && !m_i;
        m_rb = 0;
        if (LOAD) begin
            m_x = X_LOAD % H; m_y = Y_LOAD % V;
            m_vx = VX_LOAD; m_vy = VY_LOAD;
        end else if (FRAME_TICK && EN) begin
            if (!MODE) begin
                m_x = ((m_x + m_vx) % H + H) % H;
                m_y = ((m_y + m_vy) % V + V) % V;
            end else begin
                bounce_axis(m_x, m_vx, H, L, hx);
                bounce_axis(m_y, m_vy, V, A, hy);
                m_rb = hx || hy;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("x_pos", X_POS, m_x);
        chk("y_pos", Y_POS, m_y);
        chk("esterno", ESTERNO, m_e);
        chk("interno", INTERNO, m_i);
        chk("conferma", CONFERMA, m_c);
        chk("rimbalzo", RIMBALZO, m_rb);
        FRAME_TICK = 0;
        LOAD = 0;
    endtask

    task automatic do_load(input int x, input int y, input int vx, input int vy);
        X_LOAD = 11'(x); Y_LOAD = 11'(y); VX_LOAD = 6'(vx); VY_LOAD = 6'(vy);
        LOAD = 1;
        step();
    endtask

    task automatic pix(input int x, input int y);
        X_CONTROLLO = 11'(x); Y_CONTROLLO = 11'(y);
        step();
    endtask

    task automatic tick();
        FRAME_TICK = 1;
        step();
    endtask

    initial begin
        model_reset();
        step();
        step();
        chk("rst_x", X_POS, 0);
        chk("rst_esterno", ESTERNO, 0);
        RST = 0;

        pix(0, 0);    chk("t1_e00", ESTERNO, 1); chk("t1_c00", CONFERMA, 1);
        pix(99, 99);  chk("t1_e99", ESTERNO, 1); chk("t1_c99", CONFERMA, 1);
        pix(100, 0);  chk("t1_e100", ESTERNO, 0); chk("t1_c100", CONFERMA, 0);
        pix(6, 6);    chk("t1_e66", ESTERNO, 1); chk("t1_c66", CONFERMA, 0);
        pix(1300, 5); chk("t1_oob", ESTERNO, 0);

        MODE = 0; EN = 1;
        do_load(1270, 0, 5, 0);
        tick();       chk("t2_x1", X_POS, 1275);
        tick();       chk("t2_x2", X_POS, 0);
        pix(2, 10);   chk("t2_hit", ESTERNO, 1);
        do_load(1275, 0, 0, 0);
        pix(2, 10);   chk("t2_straddle", ESTERNO, 1);

        do_load(1, 0, -3, 0);
        tick();       chk("t3_x", X_POS, 1278);

        MODE = 1;
        do_load(1178, 0, 4, 0);
        tick();       chk("t4_x", X_POS, 1180); chk("t4_rb", RIMBALZO, 1);
        step();       chk("t4_rb_off", RIMBALZO, 0);
        tick();       chk("t4_x2", X_POS, 1176);

        do_load(1, 1, -2, -2);
        tick();       chk("t5_x", X_POS, 0); chk("t5_y", Y_POS, 0); chk("t5_rb", RIMBALZO, 1);
        step();       chk("t5_rb_off", RIMBALZO, 0);
        tick();       chk("t5_x2", X_POS, 2); chk("t5_y2", Y_POS, 2);

        do_load(0, 0, -32, 0);
        tick();       chk("sat_x", X_POS, 0);
        tick();       chk("sat_x2", X_POS, 31);

        EN = 0;
        tick();       chk("en_off", X_POS, 31);
        EN = 1;

        X_LOAD = 11'd500; Y_LOAD = 11'd1030; VX_LOAD = 6'sd1; VY_LOAD = 6'sd1;
        LOAD = 1; FRAME_TICK = 1;
        step();       chk("t6_ldx", X_POS, 500); chk("t6_ldy", Y_POS, 6);

        pix(510, 10);
        #3;
        RST = 1;
        #1;
        chk("t6_arst_x", X_POS, 0);
        chk("t6_arst_y", Y_POS, 0);
        chk("t6_arst_e", ESTERNO, 0);
        chk("t6_arst_c", CONFERMA, 0);
        model_reset();
        step();
        RST = 0;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                X_CONTROLLO = 11'((m_x + $urandom_range(0, 120)) % H);
                Y_CONTROLLO = 11'((m_y + $urandom_range(0, 120)) % V);
            end else begin
                X_CONTROLLO = 11'($urandom_range(0, 1400));
                Y_CONTROLLO = 11'($urandom_range(0, 1100));
            end
            if ($urandom_range(0, 199) == 0) MODE = ~MODE;
            EN = ($urandom_range(0, 3) != 0);
            FRAME_TICK = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 79) == 0) begin
                LOAD = 1;
                X_LOAD = 11'($urandom);
                Y_LOAD = 11'($urandom);
                VX_LOAD = 6'($urandom);
                VY_LOAD = 6'($urandom);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
